// File: rtl/m92_pkg.sv
// Shared types and constants for the m92 top-level wrapper.
// Holds the debug-IO sender state encoding and the latch-acknowledge limit.
package m92_pkg;

  // Debug-IO sender handshake states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STROBE   = 2'd1,
    WAIT_SET = 2'd2,
    WAIT_CLR = 2'd3
  } dbg_tx_state_t;

  // Cycles spent in WAIT_SET waiting for the latch to report busy.
  localparam int unsigned DBG_IO_WAIT_SET_LIMIT = 4;

  // Saturation-free increment used by the wrapping sent counter.
  function automatic logic [15:0] wrap_inc16(input logic [15:0] v);
    return v + 16'd1;
  endfunction

endpackage

// File: rtl/dbg_io_fifo.sv
// Generic synchronous FIFO with first-word-fall-through output.
// DEPTH must be a power of two (2..256). Flush empties it and beats a push.
module dbg_io_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [LW-1:0] CNT_ONE = LW'(1'b1);
  localparam logic [LW-1:0] CNT_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             push_eff_s;
  logic             pop_eff_s;

  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == {LW{1'b0}});
  assign push_eff_s = push & ~full & ~flush;
  assign pop_eff_s  = pop & ~empty & ~flush;
  assign dout       = mem_q[rd_ptr_q];
  assign level      = count_q;

  // Storage array: written on an accepted push, no reset needed for data.
  always_ff @(posedge clk_sys) begin
    if (push_eff_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Next pointer/occupancy: flush clears everything, otherwise track push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {LW{1'b0}};
    end else begin
      if (push_eff_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_eff_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_eff_s, pop_eff_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {LW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dbg_io_sender.sv
// Host-side transmitter for the main board debug IO latch.
// Bytes from the host are queued in a FIFO and written to the latch one at a
// time; each write waits for the CPU to drain the latch (dbg_io_wait) and for a
// short settle gap before the next strobe.
// Optional feature: define DBG_IO_SENDER_TIMEOUT_EN to add a WAIT_CLR timeout
// with a sticky timeout_flag output and a TIMEOUT parameter.
module dbg_io_sender
  import m92_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SETTLE = 2
`ifdef DBG_IO_SENDER_TIMEOUT_EN
  ,
  parameter logic [23:0] TIMEOUT = 24'd13_000_000
`endif
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   dbg_io_write,
  output logic [7:0]             dbg_io_data,
  input  logic                   dbg_io_wait,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            sent_count,
  output logic                   busy
`ifdef DBG_IO_SENDER_TIMEOUT_EN
  ,
  output logic                   timeout_flag
`endif
);

  localparam logic [7:0] SETTLE_V    = 8'(SETTLE);
  localparam logic [2:0] SET_LAST    = 3'(DBG_IO_WAIT_SET_LIMIT - 1);

  dbg_tx_state_t state_q, state_d;
  logic [7:0]    settle_q, settle_d;
  logic [2:0]    set_cnt_q, set_cnt_d;
  logic [15:0]   sent_q, sent_d;
  logic          write_q, write_d;
  logic [7:0]    data_q, data_d;
  logic          pop_s;
  logic [7:0]    fifo_dout_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
`ifdef DBG_IO_SENDER_TIMEOUT_EN
  logic [23:0]   to_cnt_q, to_cnt_d;
  logic          flag_q, flag_d;
`endif

  dbg_io_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (in_valid),
    .pop     (pop_s),
    .flush   (flush),
    .din     (in_data),
    .dout    (fifo_dout_s),
    .level   (level),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign in_ready     = ~fifo_full_s;
  assign dbg_io_write = write_q;
  assign dbg_io_data  = data_q;
  assign sent_count   = sent_q;
  assign busy         = (state_q != IDLE) || (level != {($clog2(DEPTH)+1){1'b0}});
`ifdef DBG_IO_SENDER_TIMEOUT_EN
  assign timeout_flag = flag_q;
`endif

  // Handshake sequencing: pick the next state, strobe and counters.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    set_cnt_d = set_cnt_q;
    sent_d    = sent_q;
    write_d   = 1'b0;
    data_d    = data_q;
    pop_s     = 1'b0;
`ifdef DBG_IO_SENDER_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    flag_d    = flag_q;
`endif
    case (state_q)
      IDLE: begin
        if (settle_q != 8'd0) begin
          settle_d = settle_q - 8'd1;
        end else if (!fifo_empty_s && !dbg_io_wait) begin
          // Head byte leaves the FIFO as the strobe is registered.
          pop_s   = 1'b1;
          write_d = 1'b1;
          data_d  = fifo_dout_s;
          state_d = STROBE;
        end else begin
          state_d = IDLE;
        end
      end
      STROBE: begin
        set_cnt_d = 3'd0;
        state_d   = WAIT_SET;
      end
      WAIT_SET: begin
        if (dbg_io_wait) begin
`ifdef DBG_IO_SENDER_TIMEOUT_EN
          to_cnt_d = 24'd0;
`endif
          state_d = WAIT_CLR;
        end else if (set_cnt_q == SET_LAST) begin
          // Latch never reported busy: treat the byte as delivered.
          sent_d   = wrap_inc16(sent_q);
          settle_d = SETTLE_V;
          state_d  = IDLE;
        end else begin
          set_cnt_d = set_cnt_q + 3'd1;
        end
      end
      WAIT_CLR: begin
        if (!dbg_io_wait) begin
          sent_d   = wrap_inc16(sent_q);
          settle_d = SETTLE_V;
          state_d  = IDLE;
        end else begin
`ifdef DBG_IO_SENDER_TIMEOUT_EN
          if (to_cnt_q == (TIMEOUT - 24'd1)) begin
            flag_d  = 1'b1;
            state_d = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 24'd1;
          end
`else
          state_d = WAIT_CLR;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef DBG_IO_SENDER_TIMEOUT_EN
    if (flush) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_d;
    end
`endif
  end

  // State and registered-output flops with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      settle_q  <= 8'd0;
      set_cnt_q <= 3'd0;
      sent_q    <= 16'd0;
      write_q   <= 1'b0;
      data_q    <= 8'h00;
`ifdef DBG_IO_SENDER_TIMEOUT_EN
      to_cnt_q  <= 24'd0;
      flag_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      set_cnt_q <= set_cnt_d;
      sent_q    <= sent_d;
      write_q   <= write_d;
      data_q    <= data_d;
`ifdef DBG_IO_SENDER_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      flag_q    <= flag_d;
`endif
    end
  end

endmodule

// File: tb/tb_dbg_io_sender.sv
// Self-checking bench for dbg_io_sender: scoreboard of queued bytes checked
// against every strobe, plus a latch responder model.
module tb_dbg_io_sender;

  localparam int DEPTH  = 16;
  localparam int SETTLE = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        dbg_io_write;
  logic [7:0]  dbg_io_data;
  logic        dbg_io_wait = 1'b0;
  logic [4:0]  level;
  logic [15:0] sent_count;
  logic        busy;
`ifdef DBG_IO_SENDER_TIMEOUT_EN
  logic        timeout_flag;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] sb[$];
  int n_strobes = 0;
  int last_strobe = -1;
  int last_gap = 0;
  int min_gap = 1000;
  int resp_mode = 0;   // 0: normal latch, 1: never busy, 2: wait driven by test
  int hold = 0;
  bit pend = 1'b0;
  int s0;

  dbg_io_sender #(
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
`ifdef DBG_IO_SENDER_TIMEOUT_EN
    ,
    .TIMEOUT(24'd100)
`endif
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .dbg_io_write (dbg_io_write),
    .dbg_io_data  (dbg_io_data),
    .dbg_io_wait  (dbg_io_wait),
    .level        (level),
    .sent_count   (sent_count),
    .busy         (busy)
`ifdef DBG_IO_SENDER_TIMEOUT_EN
    ,
    .timeout_flag (timeout_flag)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Strobe monitor: every strobe must carry the oldest queued byte.
  always @(negedge clk_sys) begin
    if (reset_n && dbg_io_write === 1'b1) begin
      n_strobes++;
      check_eq("sb_nonempty_at_strobe", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check_eq("strobe_data", 32'(dbg_io_data), 32'(sb.pop_front()));
      if (last_strobe >= 0) begin
        last_gap = cyc - last_strobe;
        if (last_gap < min_gap) min_gap = last_gap;
      end
      last_strobe = cyc;
    end
  end

  // Latch model: busy from the cycle after the strobe, for 10 cycles.
  always @(negedge clk_sys) begin
    if (resp_mode == 0) begin
      if (pend) begin
        dbg_io_wait = 1'b1;
        hold = 10;
        pend = 1'b0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) dbg_io_wait = 1'b0;
      end
      if (dbg_io_write === 1'b1) pend = 1'b1;
    end else begin
      pend = 1'b0;
      hold = 0;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk_sys);
    in_data  = b;
    in_valid = 1'b1;
    if (in_ready) sb.push_back(b);
    @(posedge clk_sys);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_sent(input logic [15:0] target, input int budget, input string tag);
    int k = 0;
    while (sent_count !== target && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    check_eq(tag, 32'(sent_count), 32'(target));
  endtask

  task automatic wait_strobes(input int target, input int budget, input string tag);
    int k = 0;
    while (n_strobes < target && k < budget) begin
      @(negedge clk_sys);
      #1;
      k++;
    end
    check_eq(tag, n_strobes, target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_eq("rst_write", 32'(dbg_io_write), 32'd0);
    check_eq("rst_data", 32'(dbg_io_data), 32'h00);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_sent", 32'(sent_count), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Single byte A5 then 5A back to back through the normal latch.
    resp_mode = 0;
    push_byte(8'hA5);
    push_byte(8'h5A);
    wait_sent(16'd1, 60, "sent_after_a5");
    check_eq("one_strobe_a5", n_strobes, 1);
    wait_sent(16'd2, 60, "sent_after_5a");
    check_eq("gap_a5_ge_13", 32'(min_gap >= 10 + SETTLE + 1), 32'd1);
    check_eq("sb_empty_a5", sb.size(), 0);

    // Fill to DEPTH with the latch held busy, then drain.
    repeat (5) @(negedge clk_sys);
    resp_mode = 2;
    dbg_io_wait = 1'b1;
    s0 = n_strobes;
    for (int i = 1; i <= 16; i++) push_byte(8'(i));
    @(negedge clk_sys);
    check_eq("full_level", 32'(level), 32'd16);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    push_byte(8'hFF);
    @(negedge clk_sys);
    check_eq("full_level_after_ff", 32'(level), 32'd16);
    check_eq("no_strobe_while_held", n_strobes, s0);
    min_gap = 1000;
    last_strobe = -1;
    resp_mode = 0;
    dbg_io_wait = 1'b0;
    wait_sent(16'd18, 16 * 20 + 100, "sent_16");
    check_eq("sb_empty_16", sb.size(), 0);
    check_eq("gap_16_ge_13", 32'(min_gap >= 10 + SETTLE + 1), 32'd1);

    // Latch held by another agent before the push of 3C.
    repeat (5) @(negedge clk_sys);
    resp_mode = 2;
    dbg_io_wait = 1'b1;
    s0 = n_strobes;
    push_byte(8'h3C);
    repeat (20) @(negedge clk_sys);
    check_eq("no_strobe_3c_held", n_strobes, s0);
    dbg_io_wait = 1'b0;
    resp_mode = 0;
    @(negedge clk_sys);
    check_eq("strobe_1cyc_after_release", 32'(dbg_io_write), 32'd1);
    wait_sent(16'd19, 60, "sent_3c");

    // Responder never raises wait.
    repeat (5) @(negedge clk_sys);
    resp_mode = 1;
    dbg_io_wait = 1'b0;
    last_strobe = -1;
    push_byte(8'h11);
    push_byte(8'h22);
    wait_sent(16'd21, 60, "sent_no_wait");
    check_eq("gap_no_wait", last_gap, 4 + SETTLE + 2);
    check_eq("sb_empty_no_wait", sb.size(), 0);

    // Flush with one byte mid-handshake and five queued.
    repeat (5) @(negedge clk_sys);
    resp_mode = 0;
    s0 = n_strobes;
    for (int i = 0; i < 6; i++) push_byte(8'h31 + 8'(i));
    @(negedge clk_sys);
    check_eq("level_before_flush", 32'(level), 32'd5);
    flush = 1'b1;
    @(posedge clk_sys);
    #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk_sys);
    check_eq("level_after_flush", 32'(level), 32'd0);
    wait_sent(16'd22, 40, "sent_inflight_after_flush");
    repeat (40) @(negedge clk_sys);
    check_eq("no_strobe_after_flush", n_strobes, s0 + 1);
    check_eq("idle_after_flush", 32'(busy), 32'd0);

    // Reset in the middle of a handshake abandons the byte.
    s0 = n_strobes;
    push_byte(8'h77);
    wait_strobes(s0 + 1, 20, "strobe_77");
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check_eq("midrst_sent", 32'(sent_count), 32'd0);
    check_eq("midrst_write", 32'(dbg_io_write), 32'd0);
    check_eq("midrst_level", 32'(level), 32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_sys);

`ifdef DBG_IO_SENDER_TIMEOUT_EN
    // Latch stuck busy: timeout recovers the state machine.
    resp_mode = 2;
    dbg_io_wait = 1'b0;
    repeat (5) @(negedge clk_sys);
    s0 = n_strobes;
    push_byte(8'h4B);
    wait_strobes(s0 + 1, 20, "strobe_4b");
    dbg_io_wait = 1'b1;
    repeat (50) @(negedge clk_sys);
    check_eq("to_flag_early", 32'(timeout_flag), 32'd0);
    for (int k = 0; k < 100 && timeout_flag !== 1'b1; k++) @(negedge clk_sys);
    check_eq("to_flag_set", 32'(timeout_flag), 32'd1);
    check_eq("to_sent_unchanged", 32'(sent_count), 32'd0);
    push_byte(8'h4C);
    repeat (20) @(negedge clk_sys);
    check_eq("to_no_strobe_held", n_strobes, s0 + 1);
    dbg_io_wait = 1'b0;
    wait_strobes(s0 + 2, 10, "to_strobe_after_drop");
    flush = 1'b1;
    @(posedge clk_sys);
    #1;
    flush = 1'b0;
    @(negedge clk_sys);
    check_eq("to_flag_flush", 32'(timeout_flag), 32'd0);
    repeat (10) @(negedge clk_sys);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbg_io_sender.md
Name: dbg_io_sender

Overview:
- Host-side transmitter for the main board's debug IO latch (dbg_io_write / dbg_io_data / dbg_io_wait).
- Buffers bytes from a host source (HPS ioctl or OSD injector) in a FIFO.
- Delivers one byte per latch handshake, so each byte is consumed by the main CPU (IO read of port 0x06) before the next is written.
- Sits in the top-level wrapper on clk_sys, alongside the m92 core.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- SETTLE, 2, idle cycles forced after the latch releases before the next write pulse.
- TIMEOUT, 24'd13_000_000, cycles to wait for the latch release before giving up (optional feature only).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  synchronous reset, active low.
- in_data  in  8  host byte.
- in_valid  in  1  host byte valid.
- in_ready  out  1  FIFO can accept; a byte transfers when in_valid & in_ready.
- flush  in  1  discard FIFO contents.
- dbg_io_write  out  1  single-cycle write strobe to the core latch.
- dbg_io_data  out  8  byte presented with the strobe.
- dbg_io_wait  in  1  latch busy; high from the cycle after the strobe until the CPU reads port 0x06.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- sent_count  out  16  bytes completed (latch released), wraps.
- busy  out  1  state != IDLE or level != 0.

Behaviour:
- Reset (synchronous, clk_sys, reset_n low): the following apply on the next edge.
  - FIFO empty, state IDLE, settle counter 0.
  - dbg_io_write=0, dbg_io_data=8'h00, level=0, sent_count=0, busy=0.
  - in_ready=1 combinationally once out of reset.
  - Reset mid-handshake abandons the byte. No strobe is issued in the reset cycle.
- FIFO:
  - in_ready = (level != DEPTH).
  - Push and pop in the same cycle are allowed; level is unchanged.
  - A push when full is ignored.
  - flush empties the FIFO next cycle and overrides a simultaneous push. It does not abort the state machine.
- State machine:
  - IDLE:
    - Move to STROBE when the FIFO is non-empty, dbg_io_wait=0 and the settle counter is 0.
    - The head byte is popped on the transition.
    - If dbg_io_wait=1 on entry (latch held by a previous agent), stay in IDLE.
  - STROBE (1 cycle):
    - dbg_io_write=1, dbg_io_data = popped byte (registered outputs).
    - Always go to WAIT_SET.
    - Latency: FIFO non-empty with idle conditions at cycle N gives the strobe at cycle N+1.
  - WAIT_SET:
    - Wait for dbg_io_wait=1, expected the cycle after STROBE.
    - If dbg_io_wait is still 0 after 4 cycles (responder in reset or latch already cleared), count the byte as sent and go to IDLE with settle=SETTLE.
    - On dbg_io_wait=1, go to WAIT_CLR.
  - WAIT_CLR:
    - Wait for dbg_io_wait=0.
    - Then sent_count+1, settle counter=SETTLE, go to IDLE.
  - The settle counter decrements in IDLE while nonzero.
- dbg_io_data holds its last value outside STROBE. dbg_io_write is 0 in every other state.
- Never more than one strobe per latch release: back-to-back FIFO bytes are spaced by at least the handshake time plus SETTLE+1 cycles.
- sent_count wraps 16'hFFFF to 0.

Optional Feature:
- Macro: DBG_IO_SENDER_TIMEOUT_EN.
- When defined:
  - A 24-bit counter runs in WAIT_CLR. When it reaches TIMEOUT, go to IDLE without incrementing sent_count.
  - A sticky output timeout_flag (1 bit, extra port) is set; it clears on reset or flush.
  - The next byte is still blocked while dbg_io_wait=1 in IDLE.
  - The effect is that the FIFO stalls but the state machine is recoverable.
- When not defined: WAIT_CLR waits indefinitely, with no counter and no timeout_flag port.

Decomposition:
- m92_pkg gains:
  - typedef enum logic [1:0] dbg_tx_state_t {IDLE, STROBE, WAIT_SET, WAIT_CLR}.
  - localparam DBG_IO_WAIT_SET_LIMIT = 4.
- Sub-module dbg_io_fifo: generic synchronous FIFO with parameter DEPTH; ports push/pop/flush/din/dout/level/full/empty; first-word-fall-through dout.

Test Plan:
- Push 8'hA5 with the responder model (wait rises the cycle after the strobe, falls 10 cycles later): exactly one strobe with data A5, sent_count=1, next strobe no earlier than 10+SETTLE+1 cycles later.
- Push 8'h01..8'h10 (16 bytes, DEPTH=16):
  - level reaches 16 and in_ready=0; a 17th push of 8'hFF is ignored.
  - Strobes carry 01..10 in order and sent_count=16.
- dbg_io_wait held high externally before the first push of 8'h3C: no strobe until wait falls; then the strobe comes SETTLE... cycles later, correctly 1 cycle later with settle=0.
- Responder never raises wait: after 4 cycles the state returns to IDLE, sent_count increments, and the next byte strobes.
- Flush asserted with 5 bytes queued and one mid-handshake: level=0 next cycle, the in-flight handshake completes (sent_count+1), no further strobes.
- With DBG_IO_SENDER_TIMEOUT_EN, TIMEOUT=100 and wait stuck high: timeout_flag=1 at 100 cycles in WAIT_CLR, sent_count unchanged, no strobe until wait drops.
